// File: rtl/attention_token_scheduler.sv
// Round-robin scheduler that time-shares one attention_unit between NUM_REQ token requesters.
// Optional WAIT-state watchdog: define ATTN_SCHED_TIMEOUT_EN.
module attention_token_scheduler #(
   parameter int NUM_REQ        = 2,
   parameter int EMBED_DIM      = 4,
   parameter int DATA_WIDTH     = 16,
   parameter int ID_WIDTH       = 1,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                                      clk,
   input  logic                                      rst,
   input  logic [NUM_REQ-1:0]                        req_valid,
   output logic [NUM_REQ-1:0]                        req_ready,
   input  logic [NUM_REQ*EMBED_DIM*DATA_WIDTH-1:0]   req_x,
   output logic                                      au_valid_in,
   output logic [EMBED_DIM*DATA_WIDTH-1:0]           au_x_in,
   input  logic [EMBED_DIM*DATA_WIDTH-1:0]           au_y_out,
   input  logic                                      au_valid_out,
   output logic                                      rsp_valid,
   input  logic                                      rsp_ready,
   output logic [ID_WIDTH-1:0]                       rsp_id,
   output logic [EMBED_DIM*DATA_WIDTH-1:0]           rsp_y,
   output logic                                      busy,
   output logic                                      timeout_err
);
   localparam int VW     = EMBED_DIM * DATA_WIDTH;
   localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int SCAN_W = IDX_W + 1;

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [IDX_W-1:0]    r_rr_ptr;
   logic [IDX_W-1:0]    w_grant_idx;
   logic [IDX_W-1:0]    w_rr_nxt;
   logic [SCAN_W-1:0]   w_scan;
   logic                w_grant_any;
   logic [NUM_REQ-1:0]  w_grant_oh;
   logic                w_accept;
   logic                w_capture;
   logic                w_timeout;
   logic [VW-1:0]       w_sel_x;
   logic [VW-1:0]       r_au_x;
   logic [VW-1:0]       r_rsp_y;
   logic [ID_WIDTH-1:0] r_cur_id;
   logic [ID_WIDTH-1:0] r_rsp_id;

   // Scan requesters starting at the round-robin pointer; first valid one wins.
   always_comb begin
      w_grant_any = 1'b0;
      w_grant_idx = '0;
      w_scan      = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         w_scan = {1'b0, r_rr_ptr} + SCAN_W'(k);
         if (w_scan >= SCAN_W'(NUM_REQ))
            w_scan = w_scan - SCAN_W'(NUM_REQ);
         if (!w_grant_any && req_valid[w_scan[IDX_W-1:0]]) begin
            w_grant_any = 1'b1;
            w_grant_idx = w_scan[IDX_W-1:0];
         end
      end
   end

   always_comb begin
      w_sel_x = '0;
      for (int k = 0; k < NUM_REQ; k++)
         if (w_grant_idx == IDX_W'(k))
            w_sel_x = req_x[k*VW +: VW];
   end

   assign w_grant_oh = w_grant_any ? (NUM_REQ'(1) << w_grant_idx) : '0;
   assign w_rr_nxt   = (w_grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : w_grant_idx + 1'b1;

   // Reset forces every combinational output low, even while the state register is stale.
   always_comb begin
      w_state_nxt = r_state;
      req_ready   = '0;
      au_valid_in = 1'b0;
      rsp_valid   = 1'b0;
      busy        = 1'b0;
      w_accept    = 1'b0;
      w_capture   = 1'b0;
      if (!rst) begin
         case (r_state)
            S_IDLE: begin
               req_ready = w_grant_oh;
               if (w_grant_any) begin
                  w_accept    = 1'b1;
                  w_state_nxt = S_ISSUE;
               end
            end
            S_ISSUE: begin
               busy        = 1'b1;
               au_valid_in = 1'b1;
               w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
               busy = 1'b1;
               if (au_valid_out || w_timeout) begin
                  w_capture   = 1'b1;
                  w_state_nxt = S_RESP;
               end
            end
            S_RESP: begin
               busy      = 1'b1;
               rsp_valid = 1'b1;
               if (rsp_ready)
                  w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_rr_ptr <= '0;
         r_cur_id <= '0;
         r_au_x   <= '0;
         r_rsp_y  <= '0;
         r_rsp_id <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_accept) begin
            r_au_x   <= w_sel_x;
            r_cur_id <= ID_WIDTH'(w_grant_idx);
            r_rr_ptr <= w_rr_nxt;
         end
         if (w_capture) begin
            r_rsp_y  <= w_timeout ? '0 : au_y_out;
            r_rsp_id <= r_cur_id;
         end
      end
   end

`ifdef ATTN_SCHED_TIMEOUT_EN
   logic [15:0] r_wait_cnt;
   logic        r_timeout_err;

   // Counter sits at zero outside WAIT, so it reads 0 on the first WAIT cycle.
   assign w_timeout = (r_state == S_WAIT) && !au_valid_out &&
                      (r_wait_cnt == 16'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wait_cnt    <= '0;
         r_timeout_err <= 1'b0;
      end else begin
         if (r_state == S_WAIT)
            r_wait_cnt <= r_wait_cnt + 16'd1;
         else
            r_wait_cnt <= '0;
         if (w_timeout)
            r_timeout_err <= 1'b1;
      end
   end

   assign timeout_err = r_timeout_err;
`else
   assign w_timeout   = 1'b0;
   assign timeout_err = 1'b0;
`endif

   assign au_x_in = r_au_x;
   assign rsp_y   = r_rsp_y;
   assign rsp_id  = r_rsp_id;

endmodule

// File: tb/tb_attention_token_scheduler.sv
// Randomized bench for attention_token_scheduler with a 3-cycle pass-through attention_unit stub
// and a transaction-level reference model of arbitration, issue and response timing.
`timescale 1ns/1ps
module tb_attention_token_scheduler;
   localparam int NR  = 2;
   localparam int ED  = 4;
   localparam int DW  = 16;
   localparam int IW  = 1;
   localparam int TO  = 8;
   localparam int LAT = 3;
   localparam int VW  = ED * DW;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [NR-1:0]   req_valid;
   logic [NR-1:0]   req_ready;
   logic [NR*VW-1:0] req_x;
   logic            au_valid_in;
   logic [VW-1:0]   au_x_in;
   logic [VW-1:0]   au_y_out;
   logic            au_valid_out;
   logic            rsp_valid;
   logic            rsp_ready;
   logic [IW-1:0]   rsp_id;
   logic [VW-1:0]   rsp_y;
   logic            busy;
   logic            timeout_err;

   always #5 clk = ~clk;

   attention_token_scheduler #(
      .NUM_REQ(NR), .EMBED_DIM(ED), .DATA_WIDTH(DW), .ID_WIDTH(IW), .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_x(req_x),
      .au_valid_in(au_valid_in), .au_x_in(au_x_in),
      .au_y_out(au_y_out), .au_valid_out(au_valid_out),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_y(rsp_y),
      .busy(busy), .timeout_err(timeout_err)
   );

   // Attention unit stub: y = x after LAT cycles; mute swallows issues entirely.
   logic           mute = 1'b0;
   logic [LAT-1:0] st_v = '0;
   logic [VW-1:0]  st_x [LAT];

   always @(posedge clk) begin
      st_v    <= {st_v[LAT-2:0], au_valid_in & ~mute};
      st_x[0] <= au_x_in;
      for (int k = 1; k < LAT; k++) st_x[k] <= st_x[k-1];
   end
   assign au_valid_out = st_v[LAT-1];
   assign au_y_out     = st_x[LAT-1];

   int n_chk = 0;
   int n_err = 0;
   int cyc = 0;
   int rst_cnt = 0;

   // Reference model state: one transaction in flight at most.
   int            m_ptr = 0;
   int            m_acc = 0;
   int            m_lat = 0;
   bit            m_busy = 0;
   bit            m_terr = 0;
   bit            m_mute_txn = 0;
   logic [IW-1:0] m_id;
   logic [VW-1:0] m_x;
   logic [VW-1:0] m_y;
   bit            pend [NR];
   logic [VW-1:0] tok  [NR];
   int            arrive_pct = 0;
   int            rdy_pct = 100;
   bit            ev_grant;
   bit            ev_rsp;
   int            ev_gid;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
      n_chk++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s at cycle %0d: got %0h, want %0h", tag, cyc, got, want);
      end
   endtask

   task automatic drive();
      for (int i = 0; i < NR; i++) begin
         req_valid[i]       = pend[i];
         req_x[i*VW +: VW]  = tok[i];
      end
      rsp_ready = (int'($urandom_range(99)) < rdy_pct);
   endtask

   task automatic step();
      logic [NR-1:0] exp_rdy;
      bit exp_avi;
      bit exp_rv;
      @(negedge clk);
      cyc++;
      ev_grant = 0;
      ev_rsp   = 0;
      if (rst) begin
         check_eq("rst_req_ready", req_ready, 0);
         check_eq("rst_rsp_valid", rsp_valid, 0);
         check_eq("rst_busy", busy, 0);
         check_eq("rst_au_valid_in", au_valid_in, 0);
         if (rst_cnt > 0) begin
            check_eq("rst_au_x_in", au_x_in, 0);
            check_eq("rst_rsp_y", rsp_y, 0);
            check_eq("rst_rsp_id", rsp_id, 0);
            check_eq("rst_timeout_err", timeout_err, 0);
         end
      end else begin
         exp_rdy = '0;
         if (!m_busy) begin
            for (int k = 0; k < NR; k++) begin
               int j;
               j = (m_ptr + k) % NR;
               if (!ev_grant && req_valid[j]) begin
                  exp_rdy[j] = 1'b1;
                  ev_grant   = 1;
                  ev_gid     = j;
               end
            end
         end
         check_eq("req_ready", req_ready, exp_rdy);
         check_eq("busy", busy, m_busy);
         exp_avi = m_busy && (cyc == m_acc + 1);
         check_eq("au_valid_in", au_valid_in, exp_avi);
         if (exp_avi) check_eq("au_x_in", au_x_in, m_x);
         exp_rv = m_busy && (cyc >= m_acc + m_lat);
         if (exp_rv && m_mute_txn) m_terr = 1;
         check_eq("rsp_valid", rsp_valid, exp_rv);
         if (exp_rv) begin
            check_eq("rsp_id", rsp_id, m_id);
            check_eq("rsp_y", rsp_y, m_y);
            ev_rsp = rsp_ready;
         end
         check_eq("timeout_err", timeout_err, m_terr);
      end
      @(posedge clk);
      #1;
      if (rst) begin
         rst_cnt++;
         m_busy = 0;
         m_ptr  = 0;
         m_terr = 0;
      end else begin
         rst_cnt = 0;
         if (ev_grant) begin
            m_busy     = 1;
            m_acc      = cyc;
            m_id       = IW'(ev_gid);
            m_x        = tok[ev_gid];
            m_mute_txn = mute;
            m_lat      = mute ? 2 + TO : 2 + LAT;
            m_y        = mute ? '0 : tok[ev_gid];
            m_ptr      = (ev_gid + 1) % NR;
            pend[ev_gid] = 0;
         end
         if (ev_rsp) m_busy = 0;
      end
      for (int i = 0; i < NR; i++)
         if (!pend[i] && int'($urandom_range(99)) < arrive_pct) begin
            pend[i] = 1;
            tok[i]  = {$urandom, $urandom};
         end
      drive();
   endtask

   // Step until a transaction is at (or, if !exact, past) the given cycle offset from accept.
   task automatic wait_txn(input int offs, input bit exact, input int bound);
      bit hit;
      hit = 0;
      for (int n = 0; n < bound && !hit; n++) begin
         step();
         if (m_busy && (exact ? (cyc == m_acc + offs) : (cyc >= m_acc + offs))) hit = 1;
      end
      check_eq("wait_txn_bound", hit, 1);
   endtask

   task automatic wait_drained(input int bound);
      bit done;
      done = 0;
      for (int n = 0; n < bound && !done; n++) begin
         step();
         if (!m_busy && !pend[0] && !pend[1]) done = 1;
      end
      check_eq("drain_bound", done, 1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", n_err, n_chk);
      $fatal(1, "watchdog expired");
   end

   initial begin
      req_x = '0;
      for (int i = 0; i < NR; i++) begin
         pend[i] = 1;
         tok[i]  = {$urandom, $urandom};
      end
      rdy_pct = 100;
      arrive_pct = 0;
      rst = 1'b1;
      drive();
      repeat (2) step();

      // Single request from requester 0
      pend[1] = 0;
      pend[0] = 1;
      tok[0]  = {16'd1024, 16'd768, 16'd512, 16'd256};
      rst = 1'b0;
      drive();
      repeat (10) step();

      // Both requesters continuously valid
      arrive_pct = 100;
      repeat (30) step();

      // Response backpressure
      rdy_pct = 0;
      drive();
      wait_txn(2 + LAT, 1'b0, 30);
      repeat (10) step();
      rdy_pct = 100;
      repeat (12) step();

      // Reset while the unit is busy, late stub result must be ignored
      wait_txn(2, 1'b1, 30);
      rst = 1'b1;
      arrive_pct = 0;
      for (int i = 0; i < NR; i++) pend[i] = 0;
      drive();
      step();
      check_eq("mid_rst_au_x_in", au_x_in, 0);
      check_eq("mid_rst_rsp_y", rsp_y, 0);
      check_eq("mid_rst_rsp_id", rsp_id, 0);
      rst = 1'b0;
      repeat (8) step();

      // Random arrivals and backpressure
      arrive_pct = 30;
      rdy_pct = 60;
      repeat (150) step();

`ifdef ATTN_SCHED_TIMEOUT_EN
      // Watchdog: unit never answers, then normal traffic keeps the sticky flag
      arrive_pct = 0;
      rdy_pct = 100;
      drive();
      wait_drained(80);
      mute = 1'b1;
      pend[0] = 1;
      tok[0]  = {$urandom, $urandom};
      drive();
      repeat (16) step();
      mute = 1'b0;
      arrive_pct = 100;
      repeat (30) step();
      arrive_pct = 0;
      drive();
      wait_drained(80);
`endif

      // Final reset clears everything
      rst = 1'b1;
      drive();
      repeat (2) step();
      rst = 1'b0;
      repeat (4) step();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
